neuron_pe: RTL and testbench

Parametrised multi-lane neuron processing element: the next-generation successor of the single 8-bit neuron in the MLP datapath. One input activation stream is broadcast to `LANES` neurons. Each neuron multiplies the stream by its own weight stream, adds a per-lane bias, and applies an arithmetic shift, a selectable activation and output saturation. Input and output use valid/ready handshakes, so the block can sit between a weight/activation memory streamer and the next layer's input buffer.

---
 rtl/neuron_pkg.sv | 41 ++++
 rtl/neuron_lane.sv | 54 +++++
 rtl/neuron_pe.sv | 114 +++++++++++
 tb/tb_neuron_pe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared definitions for neuron datapath blocks: activation encodings, FSM
// state encoding and the shift/activation/saturation output function.
package neuron_pkg;

    localparam logic [1:0] ACT_LINEAR = 2'd0;
    localparam logic [1:0] ACT_RELU   = 2'd1;
    localparam logic [1:0] ACT_STEP   = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    // Arithmetic shift, activation, then clamp to the signed dw-bit range.
    // Code 3 falls through as linear.
    function automatic logic signed [63:0] act_sat(
        input logic signed [63:0] acc,
        input logic [7:0]         shift,
        input logic [1:0]         mode,
        input int unsigned        dw
    );
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        r = acc >>> shift;
        if (mode == ACT_RELU && r < 64'sd0) begin
            r = 64'sd0;
        end else if (mode == ACT_STEP) begin
            r = (r > 64'sd0) ? 64'sd1 : 64'sd0;
        end
        max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (r > max_v) begin
            r = max_v;
        end else if (r < min_v) begin
            r = min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_lane.sv
// One neuron lane: registered product, wrapping accumulator seeded with the
// bias, and the output register loaded on entry to the output state.
module neuron_lane
    import neuron_pkg::*;
#(
    parameter int DW   = 8,
    parameter int WW   = 8,
    parameter int ACCW = 24,
    parameter int SHW  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic signed [ACCW-1:0] bias,
    input  logic                   beat,
    input  logic signed [DW-1:0]   in_data,
    input  logic signed [WW-1:0]   weight,
    input  logic                   capture,
    input  logic [SHW-1:0]         shift,
    input  logic [1:0]             act_mode,
    output logic [DW-1:0]          out_data
);

    logic signed [DW+WW-1:0] prod_reg;
    logic                    prod_valid_reg;
    logic signed [ACCW-1:0]  acc_reg;
    logic [DW-1:0]           out_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_reg       <= '0;
            prod_valid_reg <= 1'b0;
            acc_reg        <= '0;
            out_reg        <= '0;
        end else begin
            prod_valid_reg <= beat;
            if (beat) begin
                prod_reg <= in_data * weight;
            end
            // load and prod_valid_reg never coincide: no beat is in flight in IDLE
            if (load) begin
                acc_reg <= bias;
            end else if (prod_valid_reg) begin
                acc_reg <= acc_reg + ACCW'(prod_reg);
            end
            if (capture) begin
                out_reg <= DW'(act_sat(64'(acc_reg), 8'(shift), act_mode, DW));
            end
        end
    end

    assign out_data = out_reg;

endmodule

// File: rtl/neuron_pe.sv
// Multi-lane neuron processing element: one broadcast activation stream,
// LANES weight streams, valid/ready handshakes on both sides.
module neuron_pe
    import neuron_pkg::*;
#(
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int LANES = 4,
    parameter int ACCW  = 24,
    parameter int NW    = 16,
    parameter int SHW   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NW-1:0]           n_len,
    input  logic [SHW-1:0]          shift,
    input  logic [1:0]              act_mode,
    input  logic [LANES*ACCW-1:0]   bias,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_data,
    input  logic [LANES*WW-1:0]     weight,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DW-1:0]     out_data,
    output logic                    busy
);

    logic [1:0]     state_reg;
    logic [1:0]     state_next;
    logic [NW-1:0]  cnt_reg;
    logic [NW-1:0]  len_reg;
    logic [SHW-1:0] shift_reg;
    logic [1:0]     mode_reg;
    logic           drain_reg;

    logic accept_start;
    logic beat;
    logic last_beat;
    logic capture;

    assign accept_start = (state_reg == ST_IDLE) && start;
    assign beat         = (state_reg == ST_ACCUM) && in_valid;
    assign last_beat    = beat && (({1'b0, cnt_reg} + (NW+1)'(1)) == {1'b0, len_reg});
    // Second DRAIN cycle: the last product has reached the accumulator
    assign capture      = (state_reg == ST_DRAIN) && drain_reg;

    assign in_ready  = (state_reg == ST_ACCUM);
    assign out_valid = (state_reg == ST_OUT);
    assign busy      = (state_reg != ST_IDLE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start)     state_next = (n_len == '0) ? ST_DRAIN : ST_ACCUM;
            ST_ACCUM: if (last_beat) state_next = ST_DRAIN;
            ST_DRAIN: if (drain_reg) state_next = ST_OUT;
            ST_OUT:   if (out_ready) state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            len_reg   <= '0;
            shift_reg <= '0;
            mode_reg  <= '0;
            drain_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept_start) begin
                len_reg   <= n_len;
                shift_reg <= shift;
                mode_reg  <= act_mode;
                cnt_reg   <= '0;
                drain_reg <= 1'b0;
            end else begin
                if (beat) begin
                    cnt_reg <= cnt_reg + NW'(1);
                end
                if (state_reg == ST_DRAIN) begin
                    drain_reg <= ~drain_reg;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            neuron_lane #(
                .DW   (DW),
                .WW   (WW),
                .ACCW (ACCW),
                .SHW  (SHW)
            ) u_lane (
                .clk      (clk),
                .rst      (rst),
                .load     (accept_start),
                .bias     (bias[gi*ACCW +: ACCW]),
                .beat     (beat),
                .in_data  (in_data),
                .weight   (weight[gi*WW +: WW]),
                .capture  (capture),
                .shift    (shift_reg),
                .act_mode (mode_reg),
                .out_data (out_data[gi*DW +: DW])
            );
        end
    endgenerate

endmodule

// File: tb/tb_neuron_pe.sv
// Directed and randomized bench for neuron_pe against an arithmetic
// dot-product reference model.
module tb_neuron_pe;
    localparam int DW = 8, WW = 8, LANES = 4, ACCW = 24, NW = 16, SHW = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [NW-1:0]         n_len;
    logic [SHW-1:0]        shift;
    logic [1:0]            act_mode;
    logic [LANES*ACCW-1:0] bias;
    logic                  in_valid;
    logic                  in_ready;
    logic [DW-1:0]         in_data;
    logic [LANES*WW-1:0]   weight;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*DW-1:0]   out_data;
    logic                  busy;

    neuron_pe #(.DW(DW), .WW(WW), .LANES(LANES), .ACCW(ACCW), .NW(NW), .SHW(SHW)) dut (
        .clk(clk), .rst(rst), .start(start), .n_len(n_len), .shift(shift),
        .act_mode(act_mode), .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .weight(weight), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint in_arr[64];
    longint w_arr[64][LANES];
    longint bias_arr[LANES];
    longint got[LANES];
    bit     vpat[$];

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint lane_val(input int l);
        return longint'($signed(out_data[l*DW +: DW]));
    endfunction

    // Reference: bias + sum(in*w), wrapped to ACCW bits, shifted, activated, clamped
    function automatic longint model(input int lane, input int n, input int sh, input int mode);
        longint m, acc, r;
        m = longint'(1) << ACCW;
        acc = bias_arr[lane];
        for (int k = 0; k < n; k++) acc += in_arr[k] * w_arr[k][lane];
        acc = ((acc % m) + m) % m;
        if (acc >= m / 2) acc -= m;
        r = acc >>> sh;
        if (mode == 1 && r < 0) r = 0;
        if (mode == 2) r = (r > 0) ? 1 : 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic clear_data();
        for (int l = 0; l < LANES; l++) bias_arr[l] = 0;
        for (int k = 0; k < 64; k++) begin
            in_arr[k] = 0;
            for (int l = 0; l < LANES; l++) w_arr[k][l] = 0;
        end
        vpat.delete();
    endtask

    task automatic do_pass(input string tag, input int n, input int sh, input int mode,
                           input int hold, input bit poke_start);
        int     idx, k, guard, w;
        bit     v;
        longint exp_v[LANES];
        for (int l = 0; l < LANES; l++) exp_v[l] = model(l, n, sh, mode);
        start    = 1'b1;
        n_len    = NW'(n);
        shift    = SHW'(sh);
        act_mode = 2'(mode);
        for (int l = 0; l < LANES; l++) bias[l*ACCW +: ACCW] = ACCW'(bias_arr[l]);
        tick();
        start = 1'b0;
        bias  = '1;
        check({tag, " busy_after_start"}, longint'(busy), 1);
        check({tag, " in_ready_after_start"}, longint'(in_ready), (n > 0) ? 1 : 0);
        idx = 0; k = 0; guard = 0;
        while (idx < n && guard < 500) begin
            if (vpat.size() != 0) v = (k < vpat.size()) ? vpat[k] : 1'b1;
            else                  v = ($urandom_range(0, 3) != 0);
            in_valid = v;
            in_data  = v ? DW'(in_arr[idx]) : DW'($urandom);
            for (int l = 0; l < LANES; l++)
                weight[l*WW +: WW] = v ? WW'(w_arr[idx][l]) : WW'($urandom);
            start = poke_start && (k == 1);
            check({tag, " in_ready_accum"}, longint'(in_ready), 1);
            tick();
            if (v) idx++;
            k++;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (idx < n) check({tag, " beat_timeout"}, idx, n);
        check({tag, " in_ready_drop"}, longint'(in_ready), 0);
        check({tag, " out_valid_lat1"}, longint'(out_valid), 0);
        tick();
        check({tag, " out_valid_lat2"}, longint'(out_valid), 0);
        tick();
        check({tag, " out_valid_lat3"}, longint'(out_valid), 1);
        w = 0;
        while (!out_valid && w < 20) begin
            tick();
            w++;
        end
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            start = poke_start && (h == 1);
            check({tag, " out_valid_hold"}, longint'(out_valid), 1);
            for (int l = 0; l < LANES; l++)
                check($sformatf("%s hold_lane%0d", tag, l), lane_val(l), exp_v[l]);
            tick();
        end
        start = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            got[l] = lane_val(l);
            check($sformatf("%s lane%0d", tag, l), got[l], exp_v[l]);
        end
        out_ready = 1'b1;
        start     = poke_start;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check({tag, " out_valid_after_hs"}, longint'(out_valid), 0);
        check({tag, " busy_after_hs"}, longint'(busy), 0);
        tick();
        check({tag, " busy_idle"}, longint'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; n_len = '0; shift = '0; act_mode = '0; bias = '0;
        in_valid = 1'b0; in_data = '0; weight = '0; out_ready = 1'b0;
        tick();
        tick();
        check("reset in_ready", longint'(in_ready), 0);
        check("reset out_valid", longint'(out_valid), 0);
        check("reset busy", longint'(busy), 0);
        check("reset out_data", longint'(out_data), 0);
        rst = 1'b0;
        tick();

        // Abort a pass after 2 of 5 beats, then a fresh pass must show no residue
        clear_data();
        start = 1'b1; n_len = 16'd5; shift = '0; act_mode = 2'd0; bias = '0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = 8'd50;
            for (int l = 0; l < LANES; l++) weight[l*WW +: WW] = 8'd60;
            tick();
        end
        rst = 1'b1;
        tick();
        check("midrst in_ready", longint'(in_ready), 0);
        check("midrst busy", longint'(busy), 0);
        check("midrst out_valid", longint'(out_valid), 0);
        check("midrst out_data", longint'(out_data), 0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        in_arr[0] = 3; w_arr[0][0] = 4;
        do_pass("after_rst", 1, 0, 0, 0, 1'b0);
        check("after_rst lane0 const", got[0], 12);

        clear_data();
        for (int k = 0; k < 3; k++) begin
            in_arr[k] = k + 1; w_arr[k][0] = 2; w_arr[k][1] = -1;
        end
        do_pass("basic", 3, 0, 0, 0, 1'b0);
        check("basic lane0 const", got[0], 12);
        check("basic lane1 const", got[1], -6);

        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_pass("backpressure", 3, 0, 0, 5, 1'b1);
        check("backpressure lane0 const", got[0], 12);
        check("backpressure lane1 const", got[1], -6);

        clear_data();
        for (int k = 0; k < 4; k++) begin
            in_arr[k] = 127; w_arr[k][0] = 127; w_arr[k][1] = -128;
        end
        do_pass("sat_linear", 4, 0, 0, 0, 1'b0);
        check("sat_linear lane0 const", got[0], 127);
        check("sat_linear lane1 const", got[1], -128);
        do_pass("sat_relu", 4, 0, 1, 0, 1'b0);
        check("sat_relu lane1 const", got[1], 0);

        clear_data();
        in_arr[0] = 100; w_arr[0][0] = 10;
        do_pass("shift_linear", 1, 3, 0, 0, 1'b0);
        check("shift_linear lane0 const", got[0], 125);
        do_pass("shift_step", 1, 3, 2, 0, 1'b0);
        check("shift_step lane0 const", got[0], 1);
        in_arr[0] = -2; w_arr[0][0] = 4;
        do_pass("step_neg", 1, 0, 2, 0, 1'b0);
        check("step_neg lane0 const", got[0], 0);

        clear_data();
        bias_arr[0] = -5; bias_arr[1] = 300;
        do_pass("empty_linear", 0, 0, 0, 0, 1'b0);
        check("empty_linear lane0 const", got[0], -5);
        check("empty_linear lane1 const", got[1], 127);
        do_pass("empty_relu", 0, 0, 1, 2, 1'b0);
        check("empty_relu lane0 const", got[0], 0);
        check("empty_relu lane1 const", got[1], 127);

        for (int p = 0; p < 12; p++) begin
            int n;
            clear_data();
            n = $urandom_range(0, 8);
            for (int l = 0; l < LANES; l++) bias_arr[l] = longint'($signed(24'($urandom)));
            for (int k = 0; k < n; k++) begin
                in_arr[k] = longint'($signed(8'($urandom)));
                for (int l = 0; l < LANES; l++) w_arr[k][l] = longint'($signed(8'($urandom)));
            end
            do_pass($sformatf("rand%0d", p), n, $urandom_range(0, 15), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
